// File: rtl/pulse_pkg.sv
// Shared types and constants for the 1 Hz tick receive path.
package pulse_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam int DEFAULT_DISTANCE = 100000000;
    localparam int CLK_PERIOD_NS    = 10;

endpackage

// File: rtl/gray_encode.sv
// Combinational binary-to-Gray conversion, shared by Gray counter blocks.
module gray_encode #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_bin,
    output logic [N-1:0] o_gray
);

    assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/pulse_interval_checker.sv
// Measures cycles between tick pulses and flags lock, early and missing ticks.
// Build option: define ERR_STICKY_EN to make the error outputs sticky until err_clr.
module pulse_interval_checker
    import pulse_pkg::*;
#(
    parameter int DISTANCE = DEFAULT_DISTANCE,
    parameter int TOL      = 0,
    parameter int LOCK_N   = 2,
    parameter int N        = 4,
    parameter int CW       = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pulse,
    input  logic          err_clr,
    output logic          locked,
    output logic          tick_ok,
    output logic          err_early,
    output logic          err_missing,
    output logic [CW-1:0] period,
    output logic [N-1:0]  gray_count
);

    localparam int            GW       = $clog2(LOCK_N + 1);
    localparam logic [CW-1:0] GAP_LO   = CW'(DISTANCE - TOL);
    localparam logic [CW-1:0] GAP_HI   = CW'(DISTANCE + TOL);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_N);

    state_t        r_state;
    logic [CW-1:0] r_gap;
    logic [CW-1:0] r_period;
    logic [GW-1:0] r_good;
    logic [N-1:0]  r_bin;
    logic [N-1:0]  r_gray;
    logic          r_locked;
    logic          r_tick_ok;
    logic          r_err_early;
    logic          r_err_missing;

    state_t        w_state_nxt;
    logic [CW-1:0] w_gap_nxt;
    logic [CW-1:0] w_period_nxt;
    logic [GW-1:0] w_good_nxt;
    logic [N-1:0]  w_bin_nxt;
    logic [N-1:0]  w_gray_nxt;
    logic          w_locked_nxt;
    logic          w_tick_ok_nxt;
    logic          w_early_set;
    logic          w_missing_set;
    logic          w_early_nxt;
    logic          w_missing_nxt;

    // Interval tracking: next-state, gap counter and event classification.
    always_comb begin
        w_state_nxt   = r_state;
        w_gap_nxt     = r_gap;
        w_period_nxt  = r_period;
        w_good_nxt    = r_good;
        w_bin_nxt     = r_bin;
        w_locked_nxt  = r_locked;
        w_tick_ok_nxt = 1'b0;
        w_early_set   = 1'b0;
        w_missing_set = 1'b0;
        case (r_state)
            IDLE: begin
                if (pulse) begin
                    w_state_nxt = TRACK;
                    w_gap_nxt   = CW'(1);
                    w_bin_nxt   = r_bin + N'(1);
                end else begin
                    w_gap_nxt   = '0;
                end
            end
            TRACK: begin
                if (pulse) begin
                    w_bin_nxt    = r_bin + N'(1);
                    w_period_nxt = r_gap;
                    w_gap_nxt    = CW'(1);
                    // The timeout keeps gap <= GAP_HI here, so only the low bound needs testing.
                    if (r_gap >= GAP_LO) begin
                        w_tick_ok_nxt = 1'b1;
                        if (r_good < GOOD_MAX) begin
                            w_good_nxt = r_good + GW'(1);
                        end else begin
                            w_good_nxt = GOOD_MAX;
                        end
                        w_locked_nxt = (w_good_nxt == GOOD_MAX);
                    end else begin
                        w_early_set  = 1'b1;
                        w_good_nxt   = '0;
                        w_locked_nxt = 1'b0;
                    end
                end else if (r_gap == GAP_HI) begin
                    w_missing_set = 1'b1;
                    w_good_nxt    = '0;
                    w_locked_nxt  = 1'b0;
                    w_state_nxt   = IDLE;
                    w_gap_nxt     = '0;
                end else if (r_gap != '1) begin
                    w_gap_nxt = r_gap + CW'(1);
                end else begin
                    w_gap_nxt = r_gap;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gap_nxt   = '0;
            end
        endcase
    end

`ifdef ERR_STICKY_EN
    // Errors latch until cleared; a new error in the clear cycle wins.
    always_comb begin
        w_early_nxt   = w_early_set   | (r_err_early   & ~err_clr);
        w_missing_nxt = w_missing_set | (r_err_missing & ~err_clr);
    end
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;

    // Errors are single-cycle strobes.
    always_comb begin
        w_early_nxt   = w_early_set;
        w_missing_nxt = w_missing_set;
    end
`endif

    gray_encode #(.N(N)) u_gray_encode (
        .i_bin  (w_bin_nxt),
        .o_gray (w_gray_nxt)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_gap         <= '0;
            r_period      <= '0;
            r_good        <= '0;
            r_bin         <= '0;
            r_gray        <= '0;
            r_locked      <= 1'b0;
            r_tick_ok     <= 1'b0;
            r_err_early   <= 1'b0;
            r_err_missing <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_gap         <= w_gap_nxt;
            r_period      <= w_period_nxt;
            r_good        <= w_good_nxt;
            r_bin         <= w_bin_nxt;
            r_gray        <= w_gray_nxt;
            r_locked      <= w_locked_nxt;
            r_tick_ok     <= w_tick_ok_nxt;
            r_err_early   <= w_early_nxt;
            r_err_missing <= w_missing_nxt;
        end
    end

    assign locked      = r_locked;
    assign tick_ok     = r_tick_ok;
    assign err_early   = r_err_early;
    assign err_missing = r_err_missing;
    assign period      = r_period;
    assign gray_count  = r_gray;

endmodule

// File: tb/tb_pulse_interval_checker.sv
// Scoreboard bench for pulse_interval_checker with a timestamp-based reference model.
// Honours ERR_STICKY_EN in the same way as the design.
module tb_pulse_interval_checker;

    localparam int D  = 10;
    localparam int T  = 1;
    localparam int L  = 2;
    localparam int NB = 4;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pulse = 1'b0;
    logic          err_clr = 1'b0;
    logic          locked;
    logic          tick_ok;
    logic          err_early;
    logic          err_missing;
    logic [CW-1:0] period;
    logic [NB-1:0] gray_count;

    pulse_interval_checker #(
        .DISTANCE (D),
        .TOL      (T),
        .LOCK_N   (L),
        .N        (NB),
        .CW       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pulse       (pulse),
        .err_clr     (err_clr),
        .locked      (locked),
        .tick_ok     (tick_ok),
        .err_early   (err_early),
        .err_missing (err_missing),
        .period      (period),
        .gray_count  (gray_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          lck;
        bit          tick;
        bit          early;
        bit          missing;
        int unsigned per;
        bit [NB-1:0] gray;
    } exp_t;

    exp_t q[$];

    // Reference model: tracks the time of the last pulse rather than a gap counter.
    bit          m_track = 1'b0;
    int          m_k = 0;
    int          m_last = 0;
    int          m_good = 0;
    int unsigned m_period = 0;
    int          m_cnt = 0;
    bit          m_locked = 1'b0;
    bit          m_early = 1'b0;
    bit          m_missing = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step(input bit p, input bit c, input bit r);
        exp_t e;
        bit tick_ev;
        bit early_ev;
        bit miss_ev;
        int iv;
        int b;
        tick_ev  = 1'b0;
        early_ev = 1'b0;
        miss_ev  = 1'b0;
        @(negedge clk);
        pulse   = p;
        err_clr = c;
        rst     = r;
        m_k++;
        if (!r) begin
            m_track   = 1'b0;
            m_good    = 0;
            m_period  = 0;
            m_cnt     = 0;
            m_locked  = 1'b0;
            m_early   = 1'b0;
            m_missing = 1'b0;
        end else begin
            if (!m_track) begin
                if (p) begin
                    m_track = 1'b1;
                    m_last  = m_k;
                    m_cnt++;
                end
            end else begin
                iv = m_k - m_last;
                if (p) begin
                    m_cnt++;
                    m_period = iv;
                    m_last   = m_k;
                    if (iv >= D - T && iv <= D + T) begin
                        tick_ev = 1'b1;
                        if (m_good < L) m_good++;
                        m_locked = (m_good == L);
                    end else begin
                        early_ev = 1'b1;
                        m_good   = 0;
                        m_locked = 1'b0;
                    end
                end else if (iv == D + T) begin
                    miss_ev  = 1'b1;
                    m_good   = 0;
                    m_locked = 1'b0;
                    m_track  = 1'b0;
                end
            end
`ifdef ERR_STICKY_EN
            m_early   = early_ev | (m_early & !c);
            m_missing = miss_ev  | (m_missing & !c);
`else
            m_early   = early_ev;
            m_missing = miss_ev;
`endif
        end
        b         = m_cnt % (1 << NB);
        e.lck     = m_locked;
        e.tick    = tick_ev;
        e.early   = m_early;
        e.missing = m_missing;
        e.per     = m_period;
        e.gray    = NB'(b ^ (b >> 1));
        q.push_back(e);
    endtask

    // Pulse after g cycles; err_clr asserted with probability 1/clr_div (0 = never).
    task automatic gap(input int g, input int clr_div);
        bit c;
        for (int j = 1; j <= g; j++) begin
            c = (clr_div != 0) && ($urandom_range(0, clr_div - 1) == 0);
            step(j == g, c, 1'b1);
        end
    endtask

    // Monitor: the DUT presents a result every cycle, checked against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("locked",      64'(locked),      64'(e.lck));
                chk("tick_ok",     64'(tick_ok),     64'(e.tick));
                chk("err_early",   64'(err_early),   64'(e.early));
                chk("err_missing", 64'(err_missing), 64'(e.missing));
                chk("period",      64'(period),      64'(e.per));
                chk("gray_count",  64'(gray_count),  64'(e.gray));
            end
        end
    end

    initial begin
        // Reset held with pulse toggling, then a quiet idle stretch.
        for (int i = 0; i < 6; i++) step(i[0], 1'b0, 1'b0);
        repeat (50) step(1'b0, 1'b0, 1'b1);

        // Nominal stream and lock.
        step(1'b1, 1'b0, 1'b1);
        repeat (3) gap(D, 0);

        // Early pulse after lock, then relock.
        gap(8, 0);
        repeat (3) gap(D, 0);

        // Missing pulse, restart from IDLE and relock.
        repeat (15) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        repeat (3) gap(D, 0);

        // Tolerance boundaries and a just-too-late pulse.
        gap(D - T, 0);
        gap(D + T, 0);
        gap(D + T + 1, 0);
        repeat (2) gap(D, 0);

        // Early error held, then cleared on a cycle that raises a new error.
        gap(5, 0);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // Pulse held high: back-to-back pulses are early.
        repeat (3) step(1'b1, 1'b0, 1'b1);

        // Enough pulses to wrap the Gray count.
        repeat (18) gap(D, 0);

        // Reset in the middle of an interval.
        repeat (4) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        repeat (3) gap(D, 0);

        // Randomised intervals, clears and occasional resets.
        repeat (250) begin
            if ($urandom_range(0, 59) == 0) begin
                step(1'b0, 1'b0, 1'b0);
            end else begin
                gap(int'($urandom_range(1, 14)), 8);
            end
        end

        repeat (3) step(1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #5;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
